// File: rtl/io_uart_tx_if.sv
// Bus-side handshake between the memory controller's I/O slot and the UART peripheral.
interface io_uart_tx_if;
    logic [3:0] io_addr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       io_we;
    logic       io_oe;
    logic       io_sel;

    modport master (
        output io_addr, io_wdata, io_we, io_oe, io_sel,
        input  io_rdata
    );

    modport slave (
        input  io_addr, io_wdata, io_we, io_oe, io_sel,
        output io_rdata
    );
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO, status/control registers, switch readback,
// one-cycle registered reads and an edge-detected write strobe.
module io_uart_tx #(
    parameter int unsigned CLK_DIV    = 234,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    io_uart_tx_if.slave       bus,
    input  logic [3:0]        switches,
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              irq
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);

    localparam logic [3:0] A_TXDATA = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h1;
    localparam logic [3:0] A_CTRL   = 4'h2;
    localparam logic [3:0] A_SWITCH = 4'h3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic             tx_n, busy_n;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full;
    logic             push, push_ok, pop;

    logic             we_prev, oe_prev;
    logic             wr_stb, rd_stb;
    logic             overflow, irq_en;
    logic [7:0]       rdata, rd_mux;

    // Bus strobes: one action per assertion of a held write or read
    assign wr_stb  = bus.io_sel & bus.io_we & ~we_prev;
    assign rd_stb  = bus.io_sel & bus.io_oe & ~oe_prev;
    assign push    = wr_stb && (bus.io_addr == A_TXDATA);
    assign push_ok = push && (!fifo_full || pop);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign bus.io_rdata = rdata;

    always_comb begin
        rd_mux = 8'h00;
        case (bus.io_addr)
            A_STATUS: rd_mux = {3'b000, overflow, irq_en, tx_busy, fifo_full, fifo_empty};
            A_CTRL:   rd_mux = {7'b0000000, irq_en};
            A_SWITCH: rd_mux = {4'h0, switches};
            default:  rd_mux = 8'h00;
        endcase
    end

    // Register file, FIFO pointers and interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_prev  <= 1'b0;
            oe_prev  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            rdata    <= 8'h00;
            irq      <= 1'b0;
        end else begin
            we_prev <= bus.io_sel & bus.io_we;
            oe_prev <= bus.io_sel & bus.io_oe;
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            // A drop in the same cycle as a status read keeps the flag set
            if (push && !push_ok)
                overflow <= 1'b1;
            else if (rd_stb && (bus.io_addr == A_STATUS))
                overflow <= 1'b0;
            if (wr_stb && (bus.io_addr == A_CTRL))
                irq_en <= bus.io_wdata[0];
            if (bus.io_sel && bus.io_oe)
                rdata <= rd_mux;
            irq <= irq_en & fifo_empty & ~tx_busy;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= bus.io_wdata;
    end

    // TX FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= 3'd0;
            shift   <= 8'h00;
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            uart_tx <= tx_n;
            tx_busy <= busy_n;
        end
    end

    // TX FSM next state; the line level is derived from the next state so it is registered
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr[AW-1:0]];
                    cnt_n   = BIT_LAST;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    cnt_n   = BIT_LAST;
                    idx_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_n = BIT_LAST;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n   = idx + 3'd1;
                        shift_n = shift >> 1;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == '0)
                    state_n = IDLE;
                else
                    cnt_n = cnt - CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase

        tx_n = 1'b1;
        if (state_n == START)
            tx_n = 1'b0;
        else if (state_n == DATA)
            tx_n = shift_n[0];
        busy_n = (state_n != IDLE);
    end
endmodule
